// File: rtl/frame_pkg.sv
// frame_pkg: shared types and default constants for the frame loader.
// Holds the loader state enum and the default sync byte / timeout values.
package frame_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CKSUM,
      ST_DONE
   } state_e;

   localparam logic [7:0] DEF_SYNC_BYTE   = 8'hA5;
   localparam int         DEF_TIMEOUT_CYC = 1_000_000;

endpackage

// File: rtl/frame_timer.sv
// frame_timer: inter-byte idle counter for the frame loader.
// Ports: clk, reset (sync, active-high), clear_i, enable_i, expired_o.
module frame_timer #(
   parameter int TIMEOUT_CYC = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = (count_q == CNT_W'(TIMEOUT_CYC));

endmodule

// File: rtl/frame_loader.sv
// frame_loader: turns a sync-prefixed UART byte stream into indexed
// register-file writes with done/error pulses. Optional trailing checksum
// byte enabled by macro FRAME_CKSUM_EN.
// Ports: clk, reset (sync, active-high), byte_data/byte_valid in;
// wr_en/wr_idx/wr_data, frame_done, frame_err, busy out (all registered).
module frame_loader
   import frame_pkg::*;
#(
   parameter int          FRAME_LEN   = 55,
   parameter int          IDX_W       = $clog2(FRAME_LEN),
   parameter logic [7:0]  SYNC_BYTE   = DEF_SYNC_BYTE,
   parameter int          TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       byte_data,
   input  logic             byte_valid,
   output logic             wr_en,
   output logic [IDX_W-1:0] wr_idx,
   output logic [7:0]       wr_data,
   output logic             frame_done,
   output logic             frame_err,
   output logic             busy
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic             wr_en_q, wr_en_d;
   logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
   logic [7:0]       wr_data_q, wr_data_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;
   logic             tmr_expired;
`ifdef FRAME_CKSUM_EN
   logic [7:0]       acc_q, acc_d;
`endif

   frame_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (byte_valid),
      .enable_i  ((state_q == ST_LOAD) || (state_q == ST_CKSUM)),
      .expired_o (tmr_expired)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_en_d   = 1'b0;
      wr_idx_d  = wr_idx_q;
      wr_data_d = wr_data_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
`ifdef FRAME_CKSUM_EN
      acc_d     = acc_q;
`endif
      case (state_q)
         ST_LOAD: begin
            // a byte in the expiry cycle wins over the timeout
            if (byte_valid) begin
               wr_en_d   = 1'b1;
               wr_idx_d  = cnt_q;
               wr_data_d = byte_data;
               cnt_d     = cnt_q + IDX_W'(1);
`ifdef FRAME_CKSUM_EN
               acc_d     = acc_q + byte_data;
`endif
               if (cnt_q == LAST_IDX) begin
`ifdef FRAME_CKSUM_EN
                  state_d = ST_CKSUM;
`else
                  state_d = ST_DONE;
`endif
               end
            end else if (tmr_expired) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
`ifdef FRAME_CKSUM_EN
         ST_CKSUM: begin
            if (byte_valid) begin
               if ((acc_q + byte_data) == 8'h00) begin
                  state_d = ST_DONE;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end else if (tmr_expired) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
`endif
         default: begin
            // DONE pulses once, then hunts for sync exactly like IDLE
            done_d  = (state_q == ST_DONE);
            state_d = ST_IDLE;
            if (byte_valid && (byte_data == SYNC_BYTE)) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
`ifdef FRAME_CKSUM_EN
               acc_d   = 8'h00;
`endif
            end
         end
      endcase
      busy_d = (state_d == ST_LOAD) || (state_d == ST_CKSUM);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_idx_q  <= '0;
         wr_data_q <= 8'h00;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
`ifdef FRAME_CKSUM_EN
         acc_q     <= 8'h00;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_en_q   <= wr_en_d;
         wr_idx_q  <= wr_idx_d;
         wr_data_q <= wr_data_d;
         done_q    <= done_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
`ifdef FRAME_CKSUM_EN
         acc_q     <= acc_d;
`endif
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_idx     = wr_idx_q;
   assign wr_data    = wr_data_q;
   assign frame_done = done_q;
   assign frame_err  = err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_frame_loader.sv
// tb_frame_loader: directed bench for frame_loader (vector table plus
// hand sequences). Uses FRAME_LEN=4 when FRAME_CKSUM_EN is defined.
module tb_frame_loader;

`ifdef FRAME_CKSUM_EN
   localparam int FL = 4;
`else
   localparam int FL = 55;
`endif
   localparam int         IW = $clog2(FL);
   localparam int         TO = 100;
   localparam logic [7:0] SY = 8'hA5;
   localparam int         NB = (FL > 12) ? 10 : FL - 2;
   localparam int         RI = (FL > 22) ? 20 : FL - 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    byte_data = 8'h00;
   logic          byte_valid = 1'b0;
   logic          wr_en;
   logic [IW-1:0] wr_idx;
   logic [7:0]    wr_data;
   logic          frame_done;
   logic          frame_err;
   logic          busy;

   int tests = 0;
   int fails = 0;
   int excl  = 0;

   always #5 clk = ~clk;

   frame_loader #(
      .FRAME_LEN   (FL),
      .IDX_W       (IW),
      .SYNC_BYTE   (SY),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .wr_en      (wr_en),
      .wr_idx     (wr_idx),
      .wr_data    (wr_data),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always @(negedge clk) begin
      if ((int'(wr_en) + int'(frame_done) + int'(frame_err)) > 1) excl++;
   end

   typedef struct {
      bit         bv;
      logic [7:0] bd;
      bit         wr;
      int         idx;
      logic [7:0] data;
      bit         done;
      bit         err;
      bit         bsy;
   } vec_t;

   vec_t vt[7];

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  nm, act, act, exp, exp);
      end
   endtask

   task automatic step(input bit bv, input logic [7:0] bd);
      byte_valid = bv;
      byte_data  = bd;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
   endtask

   function automatic logic [7:0] fb(input int base, input int i);
      return 8'(base + i);
   endfunction

   task automatic payload(input int base, input int from, input int to,
                          input string nm, inout logic [7:0] sum);
      int bad = 0;
      for (int i = from; i < to; i++) begin
         step(1'b1, fb(base, i));
         if (!(wr_en && int'(wr_idx) == i && wr_data == fb(base, i)
               && !frame_done && !frame_err)) bad++;
         sum = sum + fb(base, i);
      end
      chk(nm, bad, 0);
   endtask

   task automatic close_frame(input logic [7:0] sum, input string nm,
                              input bit sync_next);
`ifdef FRAME_CKSUM_EN
      step(1'b1, 8'h00 - sum);
      chk({nm, " cksum no wr"}, int'(wr_en), 0);
      chk({nm, " cksum no err"}, int'(frame_err), 0);
`endif
      chk({nm, " busy low"}, int'(busy), 0);
      if (sync_next) begin
         step(1'b1, SY);
         chk({nm, " done"}, int'(frame_done), 1);
         chk({nm, " resync busy"}, int'(busy), 1);
      end else begin
         step(1'b0, 8'h00);
         chk({nm, " done"}, int'(frame_done), 1);
         chk({nm, " no err"}, int'(frame_err), 0);
         step(1'b0, 8'h00);
         chk({nm, " done width"}, int'(frame_done), 0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: sim time exhausted");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] sum;
      int         got;
      int         bad;

      vt[0] = '{1'b1, 8'h11, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0};
      vt[1] = '{1'b1, 8'h22, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0};
      vt[2] = '{1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0};
      vt[3] = '{1'b1, SY,    1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1};
      vt[4] = '{1'b1, SY,    1'b1, 0, SY,    1'b0, 1'b0, 1'b1};
      vt[5] = '{1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1};
      vt[6] = '{1'b1, 8'h3C, 1'b1, 1, 8'h3C, 1'b0, 1'b0, 1'b1};

      // reset state, with sync bytes offered during reset
      reset = 1'b1;
      step(1'b1, SY);
      step(1'b1, SY);
      chk("rst wr_en", int'(wr_en), 0);
      chk("rst wr_idx", int'(wr_idx), 0);
      chk("rst wr_data", int'(wr_data), 0);
      chk("rst done", int'(frame_done), 0);
      chk("rst err", int'(frame_err), 0);
      chk("rst busy", int'(busy), 0);
      reset = 1'b0;
      step(1'b0, 8'h00);
      chk("post rst busy", int'(busy), 0);

      // junk before sync, sync as payload
      for (int k = 0; k < 7; k++) begin
         step(vt[k].bv, vt[k].bd);
         chk($sformatf("vec%0d wr_en", k), int'(wr_en), int'(vt[k].wr));
         if (vt[k].wr) begin
            chk($sformatf("vec%0d idx", k), int'(wr_idx), vt[k].idx);
            chk($sformatf("vec%0d data", k), int'(wr_data),
                int'(vt[k].data));
         end
         chk($sformatf("vec%0d done", k), int'(frame_done),
             int'(vt[k].done));
         chk($sformatf("vec%0d err", k), int'(frame_err), int'(vt[k].err));
         chk($sformatf("vec%0d busy", k), int'(busy), int'(vt[k].bsy));
      end
      sum = SY + 8'h3C;
      payload(0, 2, FL, "vec frame rest", sum);
      close_frame(sum, "vec frame", 1'b0);

      // full frame, then sync arriving in the DONE cycle
      step(1'b1, SY);
      sum = 8'h00;
      payload(0, 0, FL, "frame A writes", sum);
      close_frame(sum, "frame A", 1'b1);
      sum = 8'h00;
      payload(8'h80, 0, FL, "frame B writes", sum);
      close_frame(sum, "frame B", 1'b0);

      // timeout after NB bytes
      step(1'b1, SY);
      sum = 8'h00;
      payload(8'h40, 0, NB, "to writes", sum);
      got = 0;
      bad = 0;
      for (int j = 1; j <= 2 * TO; j++) begin
         step(1'b0, 8'h00);
         if (frame_done) bad++;
         if (frame_err) begin
            got = j;
            break;
         end
      end
      chk("timeout latency", got, TO + 1);
      chk("timeout no done", bad, 0);
      chk("timeout busy", int'(busy), 0);
      step(1'b0, 8'h00);
      chk("timeout err width", int'(frame_err), 0);

      // byte landing in the expiry cycle is accepted
      step(1'b1, SY);
      sum = 8'h00;
      payload(8'h60, 0, NB, "edge writes", sum);
      bad = 0;
      for (int j = 1; j <= TO; j++) begin
         step(1'b0, 8'h00);
         if (frame_err) bad++;
      end
      chk("edge no early err", bad, 0);
      step(1'b1, fb(8'h60, NB));
      sum = sum + fb(8'h60, NB);
      chk("edge byte wr_en", int'(wr_en), 1);
      chk("edge byte idx", int'(wr_idx), NB);
      chk("edge byte err", int'(frame_err), 0);
      payload(8'h60, NB + 1, FL, "edge rest", sum);
      close_frame(sum, "edge frame", 1'b0);

      // reset mid-frame, then a fresh frame
      step(1'b1, SY);
      sum = 8'h00;
      payload(8'h10, 0, RI, "abort writes", sum);
      reset = 1'b1;
      step(1'b1, fb(8'h10, RI));
      chk("mid rst wr_en", int'(wr_en), 0);
      chk("mid rst busy", int'(busy), 0);
      chk("mid rst idx", int'(wr_idx), 0);
      reset = 1'b0;
      bad = 0;
      for (int j = 0; j < 2 * TO + 10; j++) begin
         step(1'b0, 8'h00);
         if (frame_done || frame_err || wr_en || busy) bad++;
      end
      chk("abort silent", bad, 0);
      step(1'b1, SY);
      sum = 8'h00;
      payload(8'h20, 0, FL, "fresh writes", sum);
      close_frame(sum, "fresh frame", 1'b0);

`ifdef FRAME_CKSUM_EN
      // good and bad checksum on 01 02 03 04
      step(1'b1, SY);
      sum = 8'h00;
      payload(1, 0, FL, "ck good writes", sum);
      step(1'b1, 8'hF6);
      chk("ck good no err", int'(frame_err), 0);
      chk("ck good no wr", int'(wr_en), 0);
      step(1'b0, 8'h00);
      chk("ck good done", int'(frame_done), 1);
      step(1'b1, SY);
      sum = 8'h00;
      payload(1, 0, FL, "ck bad writes", sum);
      step(1'b1, 8'hF7);
      chk("ck bad err", int'(frame_err), 1);
      chk("ck bad no wr", int'(wr_en), 0);
      chk("ck bad busy", int'(busy), 0);
      step(1'b0, 8'h00);
      chk("ck bad no done", int'(frame_done), 0);
      chk("ck bad err width", int'(frame_err), 0);
`endif

      step(1'b0, 8'h00);
      chk("mutual exclusion", excl, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
